d_phy_lane_distributor: RTL and testbench

//  Downstream neighbour of d_phy_master_adapter_layer: takes its packet byte-word stream and drives the HS byte lanes.
//  Per burst: requests HS mode, emits SoT sync byte 0xB8 on every lane, then stripes packet bytes across the lanes.

---
 rtl/d_phy_lane_distributor.sv | 123 ++++++++++++
 tb/tb_d_phy_lane_distributor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/d_phy_lane_distributor.sv
// HS lane distributor: handshakes HS mode, sends SoT sync, stripes packet words
// across the byte lanes, then closes each lane with HS-trail bytes.
module d_phy_lane_distributor #(
   parameter int unsigned LANES        = 2,
   parameter int unsigned TRAIL_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [8*LANES-1:0]         s_data,
   input  logic [$clog2(LANES+1)-1:0] s_cnt,
   input  logic                       s_valid,
   input  logic                       s_last,
   output logic                       s_ready,
   output logic                       hs_req,
   input  logic                       hs_rdy,
   output logic [8*LANES-1:0]         lane_data,
   output logic [LANES-1:0]           lane_valid,
   output logic                       busy,
   output logic                       err_underrun
);

   localparam int unsigned TC_W = $clog2(TRAIL_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, REQ, SYNC, DATA, TRAIL, EOT} state_t;

   state_t             state_q, state_d;
   logic [TC_W-1:0]    tcnt_q, tcnt_d;
   logic [LANES-1:0]   last_msb_q, last_msb_d;
   logic [8*LANES-1:0] lane_data_q, lane_data_d;
   logic [LANES-1:0]   lane_valid_q, lane_valid_d;
   logic               hs_req_q, hs_req_d;
   logic               err_q, err_d;

   function automatic logic [7:0] trail_byte(input logic msb);
      return msb ? 8'h00 : 8'hFF;
   endfunction

   // Outputs are registered: each state computes what the lanes show next cycle.
   always_comb begin
      state_d      = state_q;
      tcnt_d       = tcnt_q;
      last_msb_d   = last_msb_q;
      lane_data_d  = '0;
      lane_valid_d = '0;
      err_d        = 1'b0;
      hs_req_d     = (state_q == REQ) || (state_q == SYNC) ||
                     (state_q == DATA) || (state_q == TRAIL);
      case (state_q)
         IDLE: if (s_valid) state_d = REQ;
         REQ:  if (hs_rdy) state_d = SYNC;
         SYNC: begin
            lane_data_d  = {LANES{8'hB8}};
            lane_valid_d = '1;
            state_d      = DATA;
         end
         DATA: begin
            lane_valid_d = '1;
            if (s_valid) begin
               for (int unsigned k = 0; k < LANES; k++) begin
                  if (k < 32'(s_cnt)) begin
                     lane_data_d[8*k +: 8] = s_data[8*k +: 8];
                     last_msb_d[k]         = s_data[8*k+7];
                  end else begin
                     lane_data_d[8*k +: 8] = trail_byte(last_msb_q[k]);
                  end
               end
               if (s_last) begin
                  state_d = TRAIL;
                  tcnt_d  = TC_W'(TRAIL_CYCLES);
               end
            end else begin
               // Underrun: this cycle's trail output counts as the first trail cycle.
               err_d = 1'b1;
               for (int unsigned k = 0; k < LANES; k++)
                  lane_data_d[8*k +: 8] = trail_byte(last_msb_q[k]);
               if (TRAIL_CYCLES == 1) begin
                  state_d = EOT;
               end else begin
                  state_d = TRAIL;
                  tcnt_d  = TC_W'(TRAIL_CYCLES - 1);
               end
            end
         end
         TRAIL: begin
            lane_valid_d = '1;
            for (int unsigned k = 0; k < LANES; k++)
               lane_data_d[8*k +: 8] = trail_byte(last_msb_q[k]);
            if (tcnt_q == TC_W'(1)) state_d = EOT;
            else tcnt_d = tcnt_q - TC_W'(1);
         end
         EOT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tcnt_q       <= '0;
         last_msb_q   <= '0;
         lane_data_q  <= '0;
         lane_valid_q <= '0;
         hs_req_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         last_msb_q   <= last_msb_d;
         lane_data_q  <= lane_data_d;
         lane_valid_q <= lane_valid_d;
         hs_req_q     <= hs_req_d;
         err_q        <= err_d;
      end
   end

   assign s_ready      = (state_q == DATA);
   assign busy         = (state_q != IDLE);
   assign hs_req       = hs_req_q;
   assign lane_data    = lane_data_q;
   assign lane_valid   = lane_valid_q;
   assign err_underrun = err_q;

endmodule

// File: tb/tb_d_phy_lane_distributor.sv
// Bench for d_phy_lane_distributor: 2-lane and 4-lane instances, directed and
// random bursts checked against a burst-level model of the lane streams.
module tb_d_phy_lane_distributor;

   localparam int TC = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, hs_rdy, s_valid, s_last, sel;
   logic [31:0] s_data;
   logic [2:0]  s_cnt;

   logic        rdy2, req2, bsy2, err2, rdy4, req4, bsy4, err4;
   logic [15:0] ld2;
   logic [1:0]  lv2;
   logic [31:0] ld4;
   logic [3:0]  lv4;

   d_phy_lane_distributor #(.LANES(2), .TRAIL_CYCLES(TC)) u2 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data[15:0]), .s_cnt(s_cnt[1:0]),
      .s_valid(s_valid & ~sel), .s_last(s_last), .s_ready(rdy2), .hs_req(req2),
      .hs_rdy(hs_rdy), .lane_data(ld2), .lane_valid(lv2), .busy(bsy2),
      .err_underrun(err2));

   d_phy_lane_distributor #(.LANES(4), .TRAIL_CYCLES(TC)) u4 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_cnt(s_cnt),
      .s_valid(s_valid & sel), .s_last(s_last), .s_ready(rdy4), .hs_req(req4),
      .hs_rdy(hs_rdy), .lane_data(ld4), .lane_valid(lv4), .busy(bsy4),
      .err_underrun(err4));

   logic [31:0] o_d;
   logic [3:0]  o_v;
   logic        o_rdy, o_req, o_bsy, o_err;
   assign o_d   = sel ? ld4 : {16'h0, ld2};
   assign o_v   = sel ? lv4 : {2'b00, lv2};
   assign o_rdy = sel ? rdy4 : rdy2;
   assign o_req = sel ? req4 : req2;
   assign o_bsy = sel ? bsy4 : bsy2;
   assign o_err = sel ? err4 : err2;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  v;
      logic        rdy, req, bsy, err;
   } ent_t;

   ent_t        exp_q[$];
   logic [3:0]  mmsb [2];
   logic [7:0]  pkt[$];
   int          n_cmp, n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".data"}, o_d, 32'h0);
      chk({tag, ".valid"}, {28'h0, o_v}, 32'h0);
      chk({tag, ".ready"}, {31'h0, o_rdy}, 32'h0);
      chk({tag, ".hs_req"}, {31'h0, o_req}, 32'h0);
      chk({tag, ".busy"}, {31'h0, o_bsy}, 32'h0);
      chk({tag, ".err"}, {31'h0, o_err}, 32'h0);
   endtask

   // Trail byte drives the complement of the lane's final transmitted bit.
   function automatic logic [7:0] m_trail(input logic msb);
      return {8{~msb}};
   endfunction

   task automatic present(input int w, input int nw, input bit last_ok);
      int L, N, idx, cnt;
      L = sel ? 4 : 2;
      N = pkt.size();
      for (int k = 0; k < 4; k++) begin
         idx = w * L + k;
         s_data[8*k +: 8] = (k < L && idx < N) ? pkt[idx] : 8'($urandom);
      end
      cnt     = (N - w * L < L) ? N - w * L : L;
      s_cnt   = 3'(cnt);
      s_last  = last_ok && (w == nw - 1);
      s_valid = 1'b1;
   endtask

   // mode 0: normal burst, 1: underrun after u words, 2: reset after u words
   task automatic burst(input int mode, input int u, input int dly, input string tag);
      int   L, N, W, nsend, m, cnt, n, wi;
      bit   acc;
      ent_t e;
      L = sel ? 4 : 2;
      N = pkt.size();
      W = (N + L - 1) / L;
      nsend = (mode == 0) ? W : u;
      m = sel ? 1 : 0;
      exp_q.delete();
      e.d = '0;
      for (int k = 0; k < L; k++) e.d[8*k +: 8] = 8'hB8;
      e.v = 4'((1 << L) - 1);
      e.rdy = 1'b1; e.req = 1'b1; e.bsy = 1'b1; e.err = 1'b0;
      exp_q.push_back(e);
      for (int w = 0; w < nsend; w++) begin
         cnt = (N - w * L < L) ? N - w * L : L;
         e.d = '0;
         for (int k = 0; k < L; k++)
            e.d[8*k +: 8] = (k < cnt) ? pkt[w*L+k] : m_trail(mmsb[m][k]);
         for (int k = 0; k < cnt; k++) mmsb[m][k] = pkt[w*L+k][7];
         e.rdy = (mode == 0) ? (w + 1 < W) : 1'b1;
         exp_q.push_back(e);
      end
      if (mode != 2) begin
         for (int t = 0; t < TC; t++) begin
            e.d = '0;
            for (int k = 0; k < L; k++) e.d[8*k +: 8] = m_trail(mmsb[m][k]);
            e.rdy = 1'b0;
            e.err = (mode == 1) && (t == 0);
            exp_q.push_back(e);
         end
         e.d = '0; e.v = '0; e.rdy = 1'b0; e.req = 1'b0; e.bsy = 1'b0; e.err = 1'b0;
         exp_q.push_back(e);
      end

      @(posedge clk); #1;
      present(0, nsend, mode == 0);
      n = 0;
      @(negedge clk);
      while (o_req !== 1'b1 && n < 20) begin
         chk({tag, ".idle_ready"}, {31'h0, o_rdy}, 32'h0);
         n++;
         @(negedge clk);
      end
      chk({tag, ".req_seen"}, {31'h0, o_req}, 32'h1);
      for (int i = 0; i < dly; i++) begin
         chk({tag, ".wait_req"}, {31'h0, o_req}, 32'h1);
         chk({tag, ".wait_ready"}, {31'h0, o_rdy}, 32'h0);
         chk({tag, ".wait_valid"}, {28'h0, o_v}, 32'h0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      hs_rdy = 1'b1;
      @(negedge clk);
      chk({tag, ".pre_sync0"}, {28'h0, o_v}, 32'h0);
      @(negedge clk);
      chk({tag, ".pre_sync1"}, {28'h0, o_v}, 32'h0);

      wi = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("%s[%0d].data", tag, i), o_d, exp_q[i].d);
         chk($sformatf("%s[%0d].valid", tag, i), {28'h0, o_v}, {28'h0, exp_q[i].v});
         chk($sformatf("%s[%0d].ready", tag, i), {31'h0, o_rdy}, {31'h0, exp_q[i].rdy});
         chk($sformatf("%s[%0d].hs_req", tag, i), {31'h0, o_req}, {31'h0, exp_q[i].req});
         chk($sformatf("%s[%0d].busy", tag, i), {31'h0, o_bsy}, {31'h0, exp_q[i].bsy});
         chk($sformatf("%s[%0d].err", tag, i), {31'h0, o_err}, {31'h0, exp_q[i].err});
         acc = o_rdy && s_valid;
         @(posedge clk); #1;
         if (acc) begin
            wi++;
            if (mode == 2 && wi == u) begin
               rst_n = 1'b0;
               s_valid = 1'b0;
               @(posedge clk);
               @(negedge clk);
               chk_quiet({tag, ".reset"});
               mmsb[0] = '0;
               mmsb[1] = '0;
               @(posedge clk); #1;
               rst_n = 1'b1;
               hs_rdy = 1'b0;
               return;
            end
            if (wi < nsend) present(wi, nsend, mode == 0);
            else s_valid = 1'b0;
         end
      end
      hs_rdy = 1'b0;
   endtask

   task automatic rand_pkt(input int n);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
   endtask

   initial begin
      int L, N, W, mode;
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; hs_rdy = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      s_data = '0; s_cnt = '0; sel = 1'b0;
      mmsb[0] = '0; mmsb[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("rst2");
      sel = 1'b1; #1;
      chk_quiet("rst4");
      sel = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
      burst(0, 0, 0, "t1");
      pkt = '{8'h11, 8'hA2, 8'h80};
      burst(0, 0, 1, "t2");
      rand_pkt(4);
      burst(0, 0, 10, "t3");
      rand_pkt(6);
      burst(1, 1, 0, "t4");
      pkt = '{8'h11, 8'hF0, 8'h33, 8'h44};
      burst(2, 1, 0, "t5");
      pkt = '{8'h80};
      burst(0, 0, 0, "t5b");

      sel = 1'b1;
      rand_pkt(7);
      burst(0, 0, 0, "t6a");
      rand_pkt(10);
      burst(0, 0, 2, "t6b");

      for (int r = 0; r < 12; r++) begin
         sel = 1'($urandom_range(0, 1));
         L = sel ? 4 : 2;
         N = $urandom_range(1, 3 * L + 1);
         rand_pkt(N);
         W = (N + L - 1) / L;
         mode = (W >= 2) ? $urandom_range(0, 1) : 0;
         if (mode == 1) burst(1, $urandom_range(1, W - 1), $urandom_range(0, 3), $sformatf("r%0d", r));
         else burst(0, 0, $urandom_range(0, 3), $sformatf("r%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
